// File: rtl/axis_pattern_source_pkg.sv
// rtl/axis_pattern_source_pkg.sv - shared pattern-select and state encodings for the AXIS pattern source
package axis_pattern_source_pkg;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2
  } state_e;

endpackage

// File: rtl/axis_pattern_xy_counter.sv
// rtl/axis_pattern_xy_counter.sv - raster x/y position counters with line-end and frame-end flags
module axis_pattern_xy_counter
  import axis_pattern_source_pkg::*;
#(
  parameter int unsigned C_RESO_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    restart_i,
  input  logic                    advance_i,
  input  logic [C_RESO_WIDTH-1:0] width_i,
  input  logic [C_RESO_WIDTH-1:0] height_i,
  output logic [C_RESO_WIDTH-1:0] x_o,
  output logic [C_RESO_WIDTH-1:0] y_o,
  output logic                    line_end_o,
  output logic                    frame_end_o
);

  localparam logic [C_RESO_WIDTH-1:0] ONE = 1;

  logic [C_RESO_WIDTH-1:0] x_q, x_d;
  logic [C_RESO_WIDTH-1:0] y_q, y_d;

  // Compare against size-1 so the largest representable width never wraps early.
  assign line_end_o  = (x_q == width_i - ONE);
  assign frame_end_o = line_end_o && (y_q == height_i - ONE);
  assign x_o         = x_q;
  assign y_o         = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (restart_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (line_end_o) begin
        x_d = '0;
        y_d = frame_end_o ? '0 : y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/axis_pattern_source.sv
// rtl/axis_pattern_source.sv - AXI4-Stream test-pattern video frame source
// Optional inter-line blanking: define AXIS_PATTERN_SOURCE_HBLANK_EN.
module axis_pattern_source
  import axis_pattern_source_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH   = 8,
  parameter int unsigned C_RESO_WIDTH    = 10,
  parameter int unsigned C_HBLANK_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     fsync,
  input  logic [C_RESO_WIDTH-1:0]  width,
  input  logic [C_RESO_WIDTH-1:0]  height,
  input  logic [1:0]               pattern,
  input  logic [C_PIXEL_WIDTH-1:0] solid,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready
);

  localparam int unsigned HB_W = (C_HBLANK_CYCLES > 1) ? $clog2(C_HBLANK_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_ONE = 1;
`ifdef AXIS_PATTERN_SOURCE_HBLANK_EN
  localparam bit HB_EN = (C_HBLANK_CYCLES != 0);
`else
  localparam bit HB_EN = 1'b0;
`endif

  state_e                   state_q, state_d;
  logic [C_RESO_WIDTH-1:0]  width_q, width_d;
  logic [C_RESO_WIDTH-1:0]  height_q, height_d;
  logic [1:0]               pattern_q, pattern_d;
  logic [C_PIXEL_WIDTH-1:0] solid_q, solid_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     last_q, last_d;
  logic [HB_W-1:0]          hb_cnt_q, hb_cnt_d;
  logic                     tvalid_q, tvalid_d;
  logic [C_PIXEL_WIDTH-1:0] tdata_q, tdata_d;
  logic                     tuser_q, tuser_d;
  logic                     tlast_q, tlast_d;

  logic                     start_ok, accept, load, restart;
  logic [C_RESO_WIDTH-1:0]  x, y;
  logic                     line_end, frame_end;
  logic [C_PIXEL_WIDTH-1:0] pix;

  axis_pattern_xy_counter #(
    .C_RESO_WIDTH(C_RESO_WIDTH)
  ) u_xy (
    .clk        (clk),
    .resetn     (resetn),
    .restart_i  (restart),
    .advance_i  (load),
    .width_i    (width_q),
    .height_i   (height_q),
    .x_o        (x),
    .y_o        (y),
    .line_end_o (line_end),
    .frame_end_o(frame_end)
  );

  always_comb begin
    pix = '0;
    case (pattern_q)
      PAT_HRAMP: pix = C_PIXEL_WIDTH'(x);
      PAT_VRAMP: pix = C_PIXEL_WIDTH'(y);
      PAT_CHECK: pix = (x[3] ^ y[3]) ? '1 : '0;
      PAT_SOLID: pix = solid_q;
      default:   pix = '0;
    endcase
  end

  assign start_ok = fsync && (width != '0) && (height != '0);
  assign accept   = tvalid_q && m_axis_tready;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    pattern_d    = pattern_q;
    solid_d      = solid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    last_d       = last_q;
    hb_cnt_d     = hb_cnt_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;
    restart      = 1'b0;
    load         = 1'b0;

    if (accept && last_q) begin
      frame_done_d = 1'b1;
      busy_d       = 1'b0;
      last_d       = 1'b0;
      state_d      = ST_IDLE;
    end

    // A new request overrides everything else; a pending beat still drains below.
    if (start_ok) begin
      width_d   = width;
      height_d  = height;
      pattern_d = pattern;
      solid_d   = solid;
      restart   = 1'b1;
      busy_d    = 1'b1;
      last_d    = 1'b0;
      state_d   = ST_ACTIVE;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (!last_q && (!tvalid_q || m_axis_tready)) begin
            load   = 1'b1;
            last_d = frame_end;
            if (HB_EN && line_end && !frame_end) begin
              state_d  = ST_HBLANK;
              hb_cnt_d = HB_W'(C_HBLANK_CYCLES - 1);
            end
          end
        end
        ST_HBLANK: begin
          if (hb_cnt_q == '0) state_d = ST_ACTIVE;
          else                hb_cnt_d = hb_cnt_q - HB_ONE;
        end
        default: ;
      endcase
    end

    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = pix;
      tuser_d  = (x == '0) && (y == '0);
      tlast_d  = line_end;
    end else if (accept) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      pattern_q    <= '0;
      solid_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
      hb_cnt_q     <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      pattern_q    <= pattern_d;
      solid_q      <= solid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
      hb_cnt_q     <= hb_cnt_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: doc/axis_pattern_source.md
Name: axis_pattern_source

Overview:
AXI4-Stream video frame source that drives the s_axis input of the scaler. On each fsync it emits one frame of width x height pixels:
- tuser on the first pixel of the frame
- tlast on the last pixel of every line
- pixel data taken from a selectable test pattern

It is used as a bring-up stimulus and a board-level self-test in front of the scaler pipeline.

Parameters:
C_PIXEL_WIDTH, 8, pixel data width (sum of channel widths)
C_RESO_WIDTH, 10, width of resolution inputs and x/y counters
C_HBLANK_CYCLES, 4, idle cycles inserted after each line (used only with the optional feature)

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous active-low reset
fsync  in  1  frame start request, sampled on clk
width  in  C_RESO_WIDTH  pixels per line, latched when a frame starts
height  in  C_RESO_WIDTH  lines per frame, latched when a frame starts
pattern  in  2  pattern select, latched when a frame starts
solid  in  C_PIXEL_WIDTH  constant pixel used by pattern 3, latched when a frame starts
busy  out  1  high from frame start until the last beat is accepted
frame_done  out  1  one-cycle pulse on the clock after the final beat is accepted
m_axis_tvalid  out  1  stream valid
m_axis_tdata  out  C_PIXEL_WIDTH  pixel
m_axis_tuser  out  1  start of frame
m_axis_tlast  out  1  end of line
m_axis_tready  in  1  downstream ready

Behaviour:
- Reset (resetn=0, asynchronous) forces: state IDLE, busy=0, frame_done=0, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, x=0, y=0.
- States:
  - IDLE: fsync=1 with width!=0 and height!=0 latches width/height/pattern/solid, clears x and y, sets busy, and goes to ACTIVE. fsync with width=0 or height=0 is ignored and the block stays IDLE.
  - ACTIVE: produces beats (see below).
  - HBLANK: exists only with the optional feature.
- Output register loads when load = ACTIVE && (~m_axis_tvalid || m_axis_tready). This gives full throughput of 1 pixel per clock under continuous tready.
- Latency: fsync sampled high at edge k gives m_axis_tvalid=1 with pixel (0,0) after edge k+1.
- On load:
  - tdata = pattern(x, y)
  - tuser = (x==0 && y==0)
  - tlast = (x==width-1)
  - x is incremented; at the end of a line, x wraps to 0 and y is incremented.
- After the beat with x==width-1 and y==height-1 is loaded, no further loads occur. When that beat is accepted: tvalid falls, busy falls, frame_done pulses, and the state returns to IDLE.
- While tvalid=1 and tready=0, tdata/tuser/tlast/tvalid are held stable (AXIS rule).
- Pattern select (truncate or zero-extend to C_PIXEL_WIDTH):
  - 0: x (horizontal ramp)
  - 1: y (vertical ramp)
  - 2: all ones if x[3]^y[3], else 0 (checker)
  - 3: solid
- fsync while busy: restart. The pending beat, if any, stays valid until accepted. The next loaded beat is pixel (0,0) with tuser=1, using newly latched inputs. frame_done does not pulse for the aborted frame.
- fsync on the same cycle as final-beat acceptance: frame_done pulses and the new frame starts (busy stays 1).
- width=1: every beat has tlast=1. height=1: frame ends after the first line. Both equal to 1: a single beat with tuser=tlast=1.
- Counters are C_RESO_WIDTH bits. The max width 2^C_RESO_WIDTH-1 must not wrap early.

Optional Feature:
Macro AXIS_PATTERN_SOURCE_HBLANK_EN.
- Defined: after loading a tlast beat that is not the frame's last, enter HBLANK.
  - A down-counter runs C_HBLANK_CYCLES clocks with no new loads.
  - The held beat still completes its handshake normally.
  - The block then returns to ACTIVE.
  - C_HBLANK_CYCLES=0 behaves as if the macro were undefined.
- Undefined: no HBLANK state and lines are back-to-back; C_HBLANK_CYCLES is unused.

Decomposition:
- Shared package holds:
  - pattern-select constants (PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_SOLID=3)
  - state encoding constants (ST_IDLE, ST_ACTIVE, ST_HBLANK)
- One natural sub-module, axis_pattern_xy_counter: x/y counters with line-end and frame-end flags, advance enable, and restart input.

Test Plan:
- width=4, height=2, pattern=0, tready=1: 8 beats on consecutive clocks, tdata 0,1,2,3,0,1,2,3; tuser only on beat 0; tlast on beats 3 and 7; frame_done pulses one clock after beat 7.
- Same frame with tready toggling 1,0 every clock: each beat held stable while tready=0; data sequence unchanged; 8 accepted beats total.
- width=1, height=1, pattern=3, solid=0xA5: a single beat tdata=0xA5 with tuser=1 and tlast=1; busy high for exactly 2 cycles.
- width=16, height=16, pattern=2: pixel (8,0)=0xFF, (0,0)=0x00, (8,8)=0x00.
- fsync pulsed at beat 5 of a 4x4 frame: beat 5 completes, next beat is (0,0) with tuser=1, no frame_done for the aborted frame; fsync with width=0: no output and busy stays 0.
- With AXIS_PATTERN_SOURCE_HBLANK_EN and C_HBLANK_CYCLES=3, 4x2 frame, tready=1: exactly 3 idle cycles between beat 3 and beat 4, none after beat 7; resetn asserted mid-frame drops tvalid immediately.
